// File: rtl/request_issuer.sv
// request_issuer: programmable strided request generator feeding the
// address/ID/valid/stall pipeline. A job (base, stride, count) is launched by
// a start pulse in IDLE; `count` requests are then issued with addresses
// base, base+stride, ... and free-running IDs, each held while stalled.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           job launch, honoured only in IDLE
//   base_addr       first request address (latched on accepted start)
//   stride          per-request address increment (latched on accepted start)
//   count           requests in the job (latched on accepted start)
//   busy            high in ISSUE and DONE
//   done            one-cycle pulse after the last request is accepted
//   out_address     request address
//   out_id          request ID
//   out_valid       request present
//   in_stall        downstream backpressure
//   stall_cycles    stalled-cycle count for the current job
//                   (only with REQUEST_ISSUER_STALL_CNT_EN defined)
//
// Optional feature macro: REQUEST_ISSUER_STALL_CNT_EN
// Width macros: ADDRESS_WIDTH, ID_WIDTH (defaults below if not predefined).

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module request_issuer #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned ID_INIT     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [`ADDRESS_WIDTH-1:0] base_addr,
  input  logic [`ADDRESS_WIDTH-1:0] stride,
  input  logic [COUNT_WIDTH-1:0]    count,
  output logic                      busy,
  output logic                      done,
  output logic [`ADDRESS_WIDTH-1:0] out_address,
  output logic [`ID_WIDTH-1:0]      out_id,
  output logic                      out_valid,
  input  logic                      in_stall
`ifdef REQUEST_ISSUER_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int unsigned AW = `ADDRESS_WIDTH;
  localparam int unsigned IW = `ID_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [AW-1:0]          stride_q, stride_n;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_n;
  logic [AW-1:0]          address_n;
  logic [IW-1:0]          id_n;
  logic                   valid_n;
  logic                   busy_n;
  logic                   done_n;
  logic                   xfer;
  logic                   start_accept;

  assign xfer         = out_valid & ~in_stall;
  assign start_accept = (state == IDLE) & start;

  // Next-state and next-output computation
  always_comb begin
    state_n     = state;
    stride_n    = stride_q;
    remaining_n = remaining_q;
    address_n   = out_address;
    id_n        = out_id;
    valid_n     = out_valid;

    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            stride_n    = stride;
            remaining_n = count;
            address_n   = base_addr;
            valid_n     = 1'b1;
            state_n     = ISSUE;
          end else begin
            state_n = DONE;
          end
        end
      end
      ISSUE: begin
        if (xfer) begin
          remaining_n = remaining_q - COUNT_WIDTH'(1);
          id_n        = out_id + IW'(1);
          address_n   = out_address + stride_q;
          if (remaining_q == COUNT_WIDTH'(1)) begin
            valid_n = 1'b0;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase

    // busy/done are registered copies of the state being entered
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      stride_q    <= '0;
      remaining_q <= '0;
      out_address <= '0;
      out_id      <= IW'(ID_INIT);
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      stride_q    <= stride_n;
      remaining_q <= remaining_n;
      out_address <= address_n;
      out_id      <= id_n;
      out_valid   <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

`ifdef REQUEST_ISSUER_STALL_CNT_EN
  logic [31:0] stall_cycles_n;

  // Stalled-cycle counter: cleared per job, saturating, held after done
  always_comb begin
    stall_cycles_n = stall_cycles;
    if (start_accept) begin
      stall_cycles_n = '0;
    end else if (out_valid && in_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles_n = stall_cycles + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else begin
      stall_cycles <= stall_cycles_n;
    end
  end
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_request_issuer.sv
// Testbench for request_issuer: a table of jobs is applied in order; expected
// requests are queued when each job is launched and compared as the DUT
// presents them. Hand-written sequences cover reset and reset mid-job.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module tb_request_issuer;

  localparam int unsigned AW = `ADDRESS_WIDTH;
  localparam int unsigned IW = `ID_WIDTH;
  localparam int unsigned CW = 16;
  localparam int unsigned ID_INIT_TB = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic          out_valid;
  logic          in_stall;
`ifdef REQUEST_ISSUER_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  request_issuer #(.COUNT_WIDTH(CW), .ID_INIT(ID_INIT_TB)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .stride      (stride),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .out_address (out_address),
    .out_id      (out_id),
    .out_valid   (out_valid),
    .in_stall    (in_stall)
`ifdef REQUEST_ISSUER_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [CW-1:0] cnt;
    int            stall_at;
    int            stall_len;
    bit            restart;
  } job_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } req_t;

  req_t          sb[$];
  logic [IW-1:0] exp_id;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_job(input job_t j);
    logic [AW-1:0] a;
    int k, xfers, stalls, stall_eff, budget;
    bit got_done;
    req_t r;
    a = j.base;
    for (int i = 0; i < int'(j.cnt); i++) begin
      r.addr = a;
      r.id   = exp_id;
      sb.push_back(r);
      a      = a + j.stride;
      exp_id = exp_id + IW'(1);
    end
    stall_eff = (j.stall_at < int'(j.cnt)) ? j.stall_len : 0;
    budget = int'(j.cnt) + j.stall_len + 20;

    base_addr = j.base;
    stride    = j.stride;
    count     = j.cnt;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    // Input changes while busy must have no effect
    base_addr = AW'($urandom);
    stride    = AW'($urandom);
    count     = CW'($urandom);

    k = 0; xfers = 0; stalls = 0; got_done = 0;
    while (!got_done && k <= budget) begin
      in_stall = (j.stall_len != 0) && (xfers == j.stall_at) && (stalls < j.stall_len);
      start    = j.restart && (k == 1);
      if (start) begin
        base_addr = AW'(16'hBEEF);
        count     = CW'(2);
      end
      @(negedge clk);
      if (done) begin
        got_done = 1;
      end else begin
        chk("busy_in_job", 32'(busy), 32'd1);
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_request", 32'(out_valid), 32'd0);
          end else begin
            chk("address", 32'(out_address), 32'(sb[0].addr));
            chk("id", 32'(out_id), 32'(sb[0].id));
            if (!in_stall) begin
              void'(sb.pop_front());
              xfers++;
            end else begin
              stalls++;
            end
          end
        end
      end
      if (!got_done) begin
        @(posedge clk); #1;
        k++;
      end
    end
    start    = 1'b0;
    in_stall = 1'b0;

    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_latency", 32'(k), 32'(int'(j.cnt) + stall_eff));
    chk("transfers", 32'(xfers), 32'(j.cnt));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("busy_with_done", 32'(busy), 32'd1);
    chk("valid_in_done", 32'(out_valid), 32'd0);
`ifdef REQUEST_ISSUER_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, 32'(stall_eff));
`endif
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
`ifdef REQUEST_ISSUER_STALL_CNT_EN
    chk("stall_cycles_hold", stall_cycles, 32'(stall_eff));
`endif
    sb.delete();
  endtask

  job_t jobs[8];

  initial begin
    // base, stride, count, stall_at, stall_len, restart
    jobs[0] = '{AW'(16'h0100), AW'(4), CW'(4), 0, 0, 1'b0};
    jobs[1] = '{AW'(16'h0100), AW'(4), CW'(4), 1, 3, 1'b0};
    jobs[2] = '{AW'(16'h0100), AW'(4), CW'(0), 0, 0, 1'b0};
    jobs[3] = '{AW'(16'hFFFE), AW'(1), CW'(3), 0, 0, 1'b0};
    jobs[4] = '{AW'(16'h0040), AW'(0), CW'(3), 2, 1, 1'b0};
    jobs[5] = '{AW'(16'h0300), AW'(16), CW'(5), 0, 0, 1'b1};
    jobs[6] = '{AW'(16'h1000), AW'(2), CW'(8), 7, 2, 1'b0};
    jobs[7] = '{AW'(16'h2000), AW'(3), CW'(9), 0, 0, 1'b0};

    reset = 1'b1; start = 1'b0; in_stall = 1'b0;
    base_addr = '0; stride = '0; count = '0;
    exp_id = IW'(ID_INIT_TB);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_address", 32'(out_address), 32'd0);
    chk("rst_id", 32'(out_id), 32'(IW'(ID_INIT_TB)));
`ifdef REQUEST_ISSUER_STALL_CNT_EN
    chk("rst_stall_cycles", stall_cycles, 32'd0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_job(jobs[i]);
      @(posedge clk); #1;
    end

    // Reset during a stalled ISSUE: job abandoned, no done, IDs restart
    base_addr = AW'(16'h0200); stride = AW'(8); count = CW'(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_stall = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_address", 32'(out_address), 32'h0200);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_id", 32'(out_id), 32'(IW'(ID_INIT_TB)));
    chk("midrst_done", 32'(done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    in_stall = 1'b0;
    exp_id = IW'(ID_INIT_TB);
    @(posedge clk); #1;
    run_job(jobs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
